parking_lot_ctrl: RTL and testbench

Parametrised parking-lot controller with occupancy tracking, a timed gate and request/acknowledge handshakes. It supports any number of slots and adds a gate hold timer, entry rejection and exit-error reporting, lifetime entry statistics, and same-cycle handover of a freed slot when the lot is full. It sits between the entry/exit sensor conditioning logic and the gate actuator/display drivers.

---
 rtl/parking_lot_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_parking_lot_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_ctrl.sv
// -----------------------------------------------------------------------------
// parking_lot_ctrl
//
// Purpose: tracks the occupancy of a parking lot with SLOTS slots and runs a
// timed entry/exit gate. Entry and exit requests are level-held handshakes that
// are sampled only while the gate FSM is IDLE. When a request is accepted, the
// gate opens for GATE_HOLD cycles. When the lot is full, an entry that arrives
// in the same cycle as a valid exit takes over the slot being vacated.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-low reset
//   entry_req      car waiting at entry (level)
//   exit_req       car requesting exit (level)
//   exit_slot      slot being vacated, valid with exit_req
//   entry_ack      1-cycle pulse, entry accepted
//   entry_rej      1-cycle pulse, entry refused (lot full)
//   exit_ack       1-cycle pulse, exit accepted
//   exit_err       1-cycle pulse, exit_slot empty or out of range
//   gate_open      gate actuator drive
//   full           no free slots remain
//   spots          occupancy map, bit i = slot i occupied
//   free_count     number of free slots
//   location       lowest-index free slot (0 when full)
//   assigned_slot  slot granted by the most recent entry_ack
//   total_entries  accepted entries, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module parking_lot_ctrl #(
  parameter int  SLOTS     = 8,
  parameter int  GATE_HOLD = 4,
  parameter int  CNT_W     = 16,
  localparam int SLOT_W    = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              entry_req,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] exit_slot,
  output logic              entry_ack,
  output logic              entry_rej,
  output logic              exit_ack,
  output logic              exit_err,
  output logic              gate_open,
  output logic              full,
  output logic [SLOTS-1:0]  spots,
  output logic [SLOT_W:0]   free_count,
  output logic [SLOT_W-1:0] location,
  output logic [SLOT_W-1:0] assigned_slot,
  output logic [CNT_W-1:0]  total_entries
);

  localparam int HOLD_W = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;

  localparam logic [SLOT_W:0]   FREE_ZERO  = {(SLOT_W+1){1'b0}};
  localparam logic [SLOT_W:0]   FREE_ONE   = (SLOT_W+1)'(1'b1);
  localparam logic [SLOT_W:0]   FREE_RESET = (SLOT_W+1)'(SLOTS);
  localparam logic [HOLD_W-1:0] HOLD_ZERO  = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1'b1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(GATE_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1'b1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OPEN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                entry_ack_q, entry_ack_d;
  logic                entry_rej_q, entry_rej_d;
  logic                exit_ack_q, exit_ack_d;
  logic                exit_err_q, exit_err_d;
  logic                gate_open_q, gate_open_d;
  logic                full_q, full_d;
  logic [SLOTS-1:0]    spots_q, spots_d;
  logic [SLOT_W:0]     free_count_q, free_count_d;
  logic [SLOT_W-1:0]   location_q, location_d;
  logic [SLOT_W-1:0]   assigned_slot_q, assigned_slot_d;
  logic [CNT_W-1:0]    total_entries_q, total_entries_d;

  logic                exit_hit_s;
  logic                exit_valid_s;
  logic                handover_s;
  logic                any_ack_s;

  // Lowest-index clear bit of an occupancy map; 0 when every slot is taken.
  function automatic logic [SLOT_W-1:0] lowest_free(input logic [SLOTS-1:0] map);
    logic [SLOT_W-1:0] idx;
    idx = {SLOT_W{1'b0}};
    // Scan downwards so the lowest free index is the last one written.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      idx = map[i] ? idx : SLOT_W'(i);
    end
    return idx;
  endfunction

  // Request evaluation: exit first, then entry against start-of-cycle occupancy.
  always_comb begin
    entry_ack_d     = 1'b0;
    entry_rej_d     = 1'b0;
    exit_ack_d      = 1'b0;
    exit_err_d      = 1'b0;
    handover_s      = 1'b0;
    spots_d         = spots_q;
    free_count_d    = free_count_q;
    assigned_slot_d = assigned_slot_q;
    total_entries_d = total_entries_q;

    // Match exit_slot against each real slot. An out-of-range index matches
    // nothing, so it never reads past the end of the map.
    exit_hit_s = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      exit_hit_s = (exit_slot == SLOT_W'(i)) ? spots_q[i] : exit_hit_s;
    end
    exit_valid_s = exit_req & exit_hit_s;

    if (state_q == IDLE) begin
      if (exit_req) begin
        if (exit_valid_s) begin
          exit_ack_d = 1'b1;
        end else begin
          exit_err_d = 1'b1;
        end
      end else begin
        exit_ack_d = 1'b0;
      end

      if (entry_req) begin
        if (free_count_q != FREE_ZERO) begin
          entry_ack_d     = 1'b1;
          assigned_slot_d = location_q;
        end else if (exit_valid_s) begin
          // Full lot: the entering car takes over the slot being vacated.
          entry_ack_d     = 1'b1;
          handover_s      = 1'b1;
          assigned_slot_d = exit_slot;
        end else begin
          entry_rej_d = 1'b1;
        end
      end else begin
        entry_rej_d = 1'b0;
      end

      // A handover leaves both the map and the free count untouched.
      if (exit_valid_s && !handover_s) begin
        spots_d[exit_slot] = 1'b0;
        free_count_d       = free_count_d + FREE_ONE;
      end else begin
        free_count_d = free_count_d;
      end

      // location_q is free at the start of the cycle, so it never collides
      // with the slot being vacated in the same cycle.
      if (entry_ack_d && !handover_s) begin
        spots_d[location_q] = 1'b1;
        free_count_d        = free_count_d - FREE_ONE;
      end else begin
        free_count_d = free_count_d;
      end

      if (entry_ack_d) begin
        total_entries_d = total_entries_q + CNT_ONE;
      end else begin
        total_entries_d = total_entries_q;
      end
    end else begin
      // Gate busy: requests stay held by the sensors and are re-sampled later.
      spots_d = spots_q;
    end

    location_d = lowest_free(spots_d);
    full_d     = (free_count_d == FREE_ZERO);
    any_ack_s  = entry_ack_d | exit_ack_d;
  end

  // Gate FSM next-state logic and hold-timer countdown.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (any_ack_s) begin
          state_d = OPEN;
          hold_d  = HOLD_LOAD;
        end else begin
          state_d = IDLE;
          hold_d  = HOLD_ZERO;
        end
      end
      OPEN: begin
        if (hold_q == HOLD_ZERO) begin
          state_d = IDLE;
          hold_d  = HOLD_ZERO;
        end else begin
          state_d = OPEN;
          hold_d  = hold_q - HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = HOLD_ZERO;
      end
    endcase
  end

  // Gate drive follows the upcoming state, so it rises with the ack pulse.
  always_comb begin
    gate_open_d = (state_d == OPEN);
  end

  // FSM state and hold timer registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= HOLD_ZERO;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Registered outputs and occupancy state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      entry_ack_q     <= 1'b0;
      entry_rej_q     <= 1'b0;
      exit_ack_q      <= 1'b0;
      exit_err_q      <= 1'b0;
      gate_open_q     <= 1'b0;
      full_q          <= 1'b0;
      spots_q         <= {SLOTS{1'b0}};
      free_count_q    <= FREE_RESET;
      location_q      <= {SLOT_W{1'b0}};
      assigned_slot_q <= {SLOT_W{1'b0}};
      total_entries_q <= {CNT_W{1'b0}};
    end else begin
      entry_ack_q     <= entry_ack_d;
      entry_rej_q     <= entry_rej_d;
      exit_ack_q      <= exit_ack_d;
      exit_err_q      <= exit_err_d;
      gate_open_q     <= gate_open_d;
      full_q          <= full_d;
      spots_q         <= spots_d;
      free_count_q    <= free_count_d;
      location_q      <= location_d;
      assigned_slot_q <= assigned_slot_d;
      total_entries_q <= total_entries_d;
    end
  end

  assign entry_ack     = entry_ack_q;
  assign entry_rej     = entry_rej_q;
  assign exit_ack      = exit_ack_q;
  assign exit_err      = exit_err_q;
  assign gate_open     = gate_open_q;
  assign full          = full_q;
  assign spots         = spots_q;
  assign free_count    = free_count_q;
  assign location      = location_q;
  assign assigned_slot = assigned_slot_q;
  assign total_entries = total_entries_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_lot_ctrl
//
// Directed bench with two instances:
//   dut : SLOTS=8, GATE_HOLD=4, CNT_W=16
//   dut6: SLOTS=6, GATE_HOLD=2, CNT_W=4
// The dut6 instance covers the out-of-range exit slot and counter wrap-around.
// Inputs change 1 time unit after each rising edge. Outputs are sampled at the
// same point, after the edge that registered them.
// -----------------------------------------------------------------------------
module tb_parking_lot_ctrl;

  logic        clk;
  logic        reset;
  logic        entry_req, exit_req;
  logic [2:0]  exit_slot;
  logic        entry_ack, entry_rej, exit_ack, exit_err, gate_open, full;
  logic [7:0]  spots;
  logic [3:0]  free_count;
  logic [2:0]  location, assigned_slot;
  logic [15:0] total_entries;

  logic        b_reset;
  logic        b_entry_req, b_exit_req;
  logic [2:0]  b_exit_slot;
  logic        b_entry_ack, b_entry_rej, b_exit_ack, b_exit_err, b_gate_open, b_full;
  logic [5:0]  b_spots;
  logic [3:0]  b_free_count;
  logic [2:0]  b_location, b_assigned_slot;
  logic [3:0]  b_total_entries;

  int checks = 0;
  int errors = 0;

  parking_lot_ctrl #(.SLOTS(8), .GATE_HOLD(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .exit_slot(exit_slot), .entry_ack(entry_ack), .entry_rej(entry_rej),
    .exit_ack(exit_ack), .exit_err(exit_err), .gate_open(gate_open), .full(full),
    .spots(spots), .free_count(free_count), .location(location),
    .assigned_slot(assigned_slot), .total_entries(total_entries)
  );

  parking_lot_ctrl #(.SLOTS(6), .GATE_HOLD(2), .CNT_W(4)) dut6 (
    .clk(clk), .reset(b_reset), .entry_req(b_entry_req), .exit_req(b_exit_req),
    .exit_slot(b_exit_slot), .entry_ack(b_entry_ack), .entry_rej(b_entry_rej),
    .exit_ack(b_exit_ack), .exit_err(b_exit_err), .gate_open(b_gate_open), .full(b_full),
    .spots(b_spots), .free_count(b_free_count), .location(b_location),
    .assigned_slot(b_assigned_slot), .total_entries(b_total_entries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 3'd0;
    b_reset = 1'b0; b_entry_req = 1'b0; b_exit_req = 1'b0; b_exit_slot = 3'd0;
    repeat (2) step();

    // Reset state
    chk("rst_spots", spots, 8'h00);
    chk("rst_free", free_count, 4'd8);
    chk("rst_full", full, 1'b0);
    chk("rst_loc", location, 3'd0);
    chk("rst_assigned", assigned_slot, 3'd0);
    chk("rst_total", total_entries, 16'd0);
    chk("rst_gate", gate_open, 1'b0);
    chk("rst_pulses", {entry_ack, entry_rej, exit_ack, exit_err}, 4'b0000);
    chk("rst6_free", b_free_count, 4'd6);
    chk("rst6_misc", {b_full, b_location, b_entry_rej, b_total_entries}, 9'd0);
    reset = 1'b1; b_reset = 1'b1;
    step();

    // Single entry and gate timing
    entry_req = 1'b1;
    step();
    chk("e1_ack", entry_ack, 1'b1);
    chk("e1_slot", assigned_slot, 3'd0);
    chk("e1_spots", spots, 8'h01);
    chk("e1_free", free_count, 4'd7);
    chk("e1_loc", location, 3'd1);
    chk("e1_total", total_entries, 16'd1);
    chk("e1_gate_t1", gate_open, 1'b1);
    entry_req = 1'b0;
    step();
    chk("e1_ack_pulse", entry_ack, 1'b0);
    chk("e1_gate_t2", gate_open, 1'b1);
    step();
    chk("e1_gate_t3", gate_open, 1'b1);
    step();
    chk("e1_gate_t4", gate_open, 1'b1);
    step();
    chk("e1_gate_t5", gate_open, 1'b0);

    // Fill the lot
    for (int i = 1; i < 8; i++) begin
      entry_req = 1'b1;
      step();
      chk("fill_ack", entry_ack, 1'b1);
      chk("fill_slot", assigned_slot, i);
      entry_req = 1'b0;
      repeat (4) step();
    end
    chk("full_spots", spots, 8'hFF);
    chk("full_flag", full, 1'b1);
    chk("full_free", free_count, 4'd0);
    chk("full_total", total_entries, 16'd8);
    chk("full_loc", location, 3'd0);

    // Held entry on a full lot: rejected every cycle, gate stays shut
    entry_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rej_pulse", entry_rej, 1'b1);
      chk("rej_noack", entry_ack, 1'b0);
      chk("rej_gate", gate_open, 1'b0);
    end
    entry_req = 1'b0;
    step();
    chk("rej_drop", entry_rej, 1'b0);

    // Handover: full lot, exit slot 5 and entry in the same cycle
    entry_req = 1'b1; exit_req = 1'b1; exit_slot = 3'd5;
    step();
    chk("ho_entry_ack", entry_ack, 1'b1);
    chk("ho_exit_ack", exit_ack, 1'b1);
    chk("ho_slot", assigned_slot, 3'd5);
    chk("ho_spots", spots, 8'hFF);
    chk("ho_free", free_count, 4'd0);
    chk("ho_full", full, 1'b1);
    chk("ho_total", total_entries, 16'd9);
    chk("ho_gate", gate_open, 1'b1);
    entry_req = 1'b0; exit_req = 1'b0;
    repeat (4) step();

    // Vacate slots 4..7 to reach 0x0F
    for (int i = 4; i < 8; i++) begin
      exit_req = 1'b1; exit_slot = 3'(i);
      step();
      chk("vac_ack", exit_ack, 1'b1);
      exit_req = 1'b0;
      repeat (4) step();
    end
    chk("vac_spots", spots, 8'h0F);
    chk("vac_free", free_count, 4'd4);
    chk("vac_loc", location, 3'd4);
    chk("vac_full", full, 1'b0);

    // Simultaneous entry and exit (slot 1) when not full
    entry_req = 1'b1; exit_req = 1'b1; exit_slot = 3'd1;
    step();
    chk("sim_entry_ack", entry_ack, 1'b1);
    chk("sim_exit_ack", exit_ack, 1'b1);
    chk("sim_slot", assigned_slot, 3'd4);
    chk("sim_spots", spots, 8'h1D);
    chk("sim_free", free_count, 4'd4);
    chk("sim_loc", location, 3'd1);
    chk("sim_total", total_entries, 16'd10);
    entry_req = 1'b0; exit_req = 1'b0;
    repeat (4) step();

    // Exit from an empty slot
    exit_req = 1'b1; exit_slot = 3'd6;
    step();
    chk("err_pulse", exit_err, 1'b1);
    chk("err_noack", exit_ack, 1'b0);
    chk("err_gate", gate_open, 1'b0);
    chk("err_spots", spots, 8'h1D);
    exit_req = 1'b0;
    step();
    chk("err_drop", exit_err, 1'b0);
    chk("err_gate2", gate_open, 1'b0);

    // Reset asserted while the gate is open after three entries
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      entry_req = 1'b1;
      step();
      entry_req = 1'b0;
      repeat (4) step();
    end
    entry_req = 1'b1;
    step();
    chk("r3_gate", gate_open, 1'b1);
    chk("r3_spots", spots, 8'h07);
    chk("r3_total", total_entries, 16'd3);
    entry_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("rmid_spots", spots, 8'h00);
    chk("rmid_free", free_count, 4'd8);
    chk("rmid_gate", gate_open, 1'b0);
    chk("rmid_total", total_entries, 16'd0);
    chk("rmid_full_loc", {full, location, assigned_slot}, 7'd0);
    reset = 1'b1; entry_req = 1'b1;
    step();
    chk("rmid_idle_ack", entry_ack, 1'b1);
    chk("rmid_idle_slot", assigned_slot, 3'd0);
    entry_req = 1'b0;
    repeat (4) step();

    // SLOTS=6 instance: exit slots 7 and 6 are out of range
    b_exit_req = 1'b1; b_exit_slot = 3'd7;
    step();
    chk("s6_err7", b_exit_err, 1'b1);
    chk("s6_gate7", b_gate_open, 1'b0);
    b_exit_slot = 3'd6;
    step();
    chk("s6_err6", b_exit_err, 1'b1);
    b_exit_req = 1'b0;
    step();
    chk("s6_err_drop", b_exit_err, 1'b0);

    // CNT_W=4 instance: 17 entry/exit pairs wrap total_entries to 1
    for (int i = 1; i <= 17; i++) begin
      b_entry_req = 1'b1;
      step();
      chk("w_entry_ack", b_entry_ack, 1'b1);
      chk("w_slot", b_assigned_slot, 3'd0);
      b_entry_req = 1'b0;
      repeat (2) step();
      b_exit_req = 1'b1; b_exit_slot = 3'd0;
      step();
      chk("w_exit_ack", b_exit_ack, 1'b1);
      b_exit_req = 1'b0;
      repeat (2) step();
      if (i == 16) chk("w_total16", b_total_entries, 4'd0);
    end
    chk("w_total17", b_total_entries, 4'd1);
    chk("w_spots", b_spots, 6'h00);
    chk("w_free", b_free_count, 4'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
